airlock_sequencer: RTL
======================

# airlock_sequencer

Top-level controller for the airlock chamber. It accepts door-access requests from the habitat (inner) side and the vacuum (outer) side and arbitrates between them round-robin. For the granted side it sequences a door check, a pump step (pressurize or evacuate to match that side), a timed door-open dwell and a door-close confirmation. Pump and door commands drive the chamber actuators directly; door and pressure sensors feed back in, and every wait is bounded by a timeout that latches a sticky fault.

## Interface
Parameters:
- DWELL_CYCLES, default 8: cycles a door-open command is held.
- PUMP_TIMEOUT, default 64: max cycles in a pump state before fault.
- DOOR_TIMEOUT, default 32: max cycles waiting for doors closed before fault.

Ports:
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high; clears all state and outputs on the next posedge.
- ReqInner  in  1  level request, inner side wants the inner door opened.
- ReqOuter  in  1  level request, outer side wants the outer door opened.
- InnerClosed  in  1  inner door sensor, 1 = closed.
- OuterClosed  in  1  outer door sensor, 1 = closed.
- Pressurized  in  1  chamber at habitat pressure.
- Evacuated  in  1  chamber at vacuum.
- Pressurize  out  1  pump-up command.
- Evacuate  out  1  pump-down command.
- OpenInner  out  1  inner door open command.
- OpenOuter  out  1  outer door open command.
- GrantInner  out  1  inner request being serviced.
- GrantOuter  out  1  outer request being serviced.
- Busy  out  1  high in any state other than IDLE or FAULT.
- Fault  out  1  sticky fault; cleared only by Reset.

## Operation
- Moore FSM, states: IDLE, CHECK, PUMP, OPEN, CLOSE, FAULT. A `side` register (INNER/OUTER) holds the current grant. A `last` register holds the last side served; its reset value is OUTER, so INNER wins the first tie.
- IDLE: if exactly one request is high, grant that side; if both are high, grant the side != `last`. Go to CHECK. With no request, stay.
- CHECK: wait for InnerClosed && OuterClosed. Then go to OPEN if the target is met (INNER needs Pressurized, OUTER needs Evacuated), else go to PUMP. Timeout after DOOR_TIMEOUT cycles goes to FAULT.
- PUMP: assert Pressurize (INNER) or Evacuate (OUTER), never both.
  - Target sensor high: go to OPEN.
  - Either door sensor drops: go to FAULT immediately.
  - PUMP_TIMEOUT cycles elapse: go to FAULT.
- OPEN: assert OpenInner or OpenOuter for exactly DWELL_CYCLES cycles, then go to CLOSE.
- CLOSE: wait for the granted door's closed sensor, then go to IDLE and set `last` = `side`. Timeout after DOOR_TIMEOUT cycles goes to FAULT.
- FAULT: all actuator outputs are 0, no grants, Fault = 1. Requests are ignored until Reset.
- Pressurized && Evacuated both high in CHECK, PUMP, OPEN or CLOSE means a sensor conflict: go to FAULT.
- GrantInner/GrantOuter are high from CHECK through CLOSE.
- Requests are levels. A request still high on return to IDLE is treated as a new request and arbitrated normally.

## Timing
- Reset: state IDLE, `last` = OUTER, counter 0. Every output is 0 in the cycle after the Reset posedge.
- A request sampled at edge N in IDLE gives Grant* = 1 and state CHECK after edge N.
- When the sensors already match in CHECK, the door command is asserted one cycle after entering CHECK.
- The cycle counter clears on every state transition and increments each cycle otherwise. Timeout fires when the counter reaches limit-1 without the exit condition, so FAULT is entered on edge number `limit` counted from state entry.
- Counter width is $clog2 of max(DWELL_CYCLES, PUMP_TIMEOUT, DOOR_TIMEOUT), plus 1.
- If an exit condition and a timeout occur in the same cycle, the exit condition wins.
- Fault has priority over all transitions except Reset. Reset mid-sequence drops all commands in one cycle.

## Structure
- airlock_pkg holds the state enum, the side enum (INNER/OUTER), and the timeout/dwell default constants.
- Sub-module airlock_timer: a loadable up-counter with clear and a terminal-count compare, taking the limit as an input. It is instantiated once and its limit is muxed by state.

## Test plan
- ReqInner pulse, doors closed, Pressurized = 1: GrantInner at cycle 1, OpenInner high for cycles 2-9, then InnerClosed returns, IDLE, Busy = 0.
- ReqOuter, chamber pressurized: Evacuate asserted from cycle 2. Evacuated driven high at cycle 10 gives OpenOuter at cycle 11 for 8 cycles; Pressurize stays 0 throughout.
- ReqInner and ReqOuter high together and held: service order INNER, OUTER, INNER. Exactly one grant is high at any time.
- ReqInner, chamber evacuated, Pressurized never rises: FAULT entered 64 cycles after PUMP entry. Fault stays 1 with all commands 0 until Reset, after which all outputs are 0.
- OuterClosed dropped mid-PUMP: FAULT on the next edge. Pressurized && Evacuated both high in CHECK: FAULT on the next edge.
- Reset asserted during OPEN: the door command drops the next cycle and a later request restarts cleanly from IDLE.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared types and default timing constants for the airlock chamber sequencer.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PUMP,
    ST_OPEN,
    ST_CLOSE,
    ST_FAULT
  } state_e;

  typedef enum logic {
    SIDE_INNER = 1'b0,
    SIDE_OUTER = 1'b1
  } side_e;

  localparam int unsigned DWELL_CYCLES_DEFAULT = 8;
  localparam int unsigned PUMP_TIMEOUT_DEFAULT = 64;
  localparam int unsigned DOOR_TIMEOUT_DEFAULT = 32;

  typedef struct packed {
    logic pressurize;
    logic evacuate;
    logic open_inner;
    logic open_outer;
    logic grant_inner;
    logic grant_outer;
    logic busy;
    logic fault;
  } cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Moore decode: every actuator, grant and status bit is a pure function of state and side.
  function automatic cmd_t decode_cmd(input state_e state, input side_e side);
    cmd_t cmd;
    cmd = '0;
    if (state inside {ST_CHECK, ST_PUMP, ST_OPEN, ST_CLOSE}) begin
      cmd.busy        = 1'b1;
      cmd.grant_inner = (side == SIDE_INNER);
      cmd.grant_outer = (side == SIDE_OUTER);
    end
    if (state == ST_PUMP) begin
      cmd.pressurize = (side == SIDE_INNER);
      cmd.evacuate   = (side == SIDE_OUTER);
    end
    if (state == ST_OPEN) begin
      cmd.open_inner = (side == SIDE_INNER);
      cmd.open_outer = (side == SIDE_OUTER);
    end
    cmd.fault = (state == ST_FAULT);
    return cmd;
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Per-state cycle counter: cleared on state change, saturating up-count, and a
// terminal-count flag raised when the count reaches limit-1.
module airlock_timer #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: assign a default first so every path through always_comb drives count_d (no latch).
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit - CNT_W'(1));

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber controller: round-robin arbitration between inner and outer
// door requests, then check / pump / open-dwell / close with bounded waits.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEFAULT,
  parameter int unsigned PUMP_TIMEOUT = PUMP_TIMEOUT_DEFAULT,
  parameter int unsigned DOOR_TIMEOUT = DOOR_TIMEOUT_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic ReqInner,
  input  logic ReqOuter,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Pressurized,
  input  logic Evacuated,
  output logic Pressurize,
  output logic Evacuate,
  output logic OpenInner,
  output logic OpenOuter,
  output logic GrantInner,
  output logic GrantOuter,
  output logic Busy,
  output logic Fault
);

  localparam int unsigned CNT_W = $clog2(max3(DWELL_CYCLES, PUMP_TIMEOUT, DOOR_TIMEOUT)) + 1;

  state_e           state_q, state_d;
  side_e            side_q, side_d;
  side_e            last_q, last_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] limit;
  logic             timer_clear;
  logic             timer_tc;
  logic             conflict;
  logic             doors_closed;
  logic             target_met;
  logic             granted_closed;

  assign conflict       = Pressurized && Evacuated;
  assign doors_closed   = InnerClosed && OuterClosed;
  assign target_met     = (side_q == SIDE_INNER) ? Pressurized : Evacuated;
  assign granted_closed = (side_q == SIDE_INNER) ? InnerClosed : OuterClosed;

  always_comb begin
    case (state_q)
      ST_PUMP: limit = CNT_W'(PUMP_TIMEOUT);
      ST_OPEN: limit = CNT_W'(DWELL_CYCLES);
      default: limit = CNT_W'(DOOR_TIMEOUT);
    endcase
  end

  assign timer_clear = (state_d != state_q);

  airlock_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (Clock),
    .rst  (Reset),
    .clear(timer_clear),
    .limit(limit),
    .tc   (timer_tc)
  );

  // Within each state: fault conditions first, then the exit condition, then the timeout.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqInner || ReqOuter) begin
          state_d = ST_CHECK;
          if (ReqInner && ReqOuter) begin
            side_d = (last_q == SIDE_INNER) ? SIDE_OUTER : SIDE_INNER;
          end else begin
            side_d = ReqInner ? SIDE_INNER : SIDE_OUTER;
          end
        end
      end
      ST_CHECK: begin
        if (conflict)          state_d = ST_FAULT;
        else if (doors_closed) state_d = target_met ? ST_OPEN : ST_PUMP;
        else if (timer_tc)     state_d = ST_FAULT;
      end
      ST_PUMP: begin
        if (conflict || !doors_closed) state_d = ST_FAULT;
        else if (target_met)           state_d = ST_OPEN;
        else if (timer_tc)             state_d = ST_FAULT;
      end
      ST_OPEN: begin
        if (conflict)      state_d = ST_FAULT;
        else if (timer_tc) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (conflict) begin
          state_d = ST_FAULT;
        end else if (granted_closed) begin
          state_d = ST_IDLE;
          last_d  = side_q;
        end else if (timer_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign cmd_d = decode_cmd(state_d, side_d);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      side_q  <= SIDE_INNER;
      last_q  <= SIDE_OUTER;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
    end
  end

  assign Pressurize = cmd_q.pressurize;
  assign Evacuate   = cmd_q.evacuate;
  assign OpenInner  = cmd_q.open_inner;
  assign OpenOuter  = cmd_q.open_outer;
  assign GrantInner = cmd_q.grant_inner;
  assign GrantOuter = cmd_q.grant_outer;
  assign Busy       = cmd_q.busy;
  assign Fault      = cmd_q.fault;

endmodule
